// File: rtl/fruit_scheduler.sv
// fruit_scheduler: spawns, holds and retires the single fruit of the snake game.
//
// Flow: WAIT counts game ticks, then REQ fetches a candidate from the fruit
// generator, CHECK asks the snake body whether the square is free, and ACTIVE
// holds the placed fruit until it is eaten (or, optionally, times out).
// Rejected candidates are retried up to MAX_RETRY times per attempt.
//
// Parameters:
//   LIFETIME_TICKS - ticks a placed fruit stays active (timeout build only)
//   RESPAWN_TICKS  - ticks waited with no fruit before a spawn attempt
//   MAX_RETRY      - rejected candidates allowed per spawn attempt
//
// Ports:
//   clk, reset                         - clock (rising edge), async active-high reset
//   tick, eaten                        - one-cycle game-tick and snake-on-fruit pulses
//   gen_req / cand_*                   - candidate request and response from generator
//   chk_req, chk_x, chk_y / chk_ack,
//   chk_hit                            - occupancy check toward the snake body
//   fruit_valid, fruit_x/y/type        - currently placed fruit
//   eat_evt, eat_type                  - one-cycle consumption pulse with fruit type
//   spawn_fail                         - one-cycle pulse when an attempt runs out of retries
//
// Build option: define FRUIT_TIMEOUT_EN to retire an uneaten fruit after
// LIFETIME_TICKS ticks; otherwise a fruit stays until eaten.
module fruit_scheduler #(
    parameter int unsigned LIFETIME_TICKS = 64,
    parameter int unsigned RESPAWN_TICKS  = 4,
    parameter int unsigned MAX_RETRY      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       eaten,
    output logic       gen_req,
    input  logic       cand_valid,
    input  logic [9:0] cand_x,
    input  logic [8:0] cand_y,
    input  logic [1:0] cand_type,
    output logic       chk_req,
    output logic [9:0] chk_x,
    output logic [8:0] chk_y,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic       fruit_valid,
    output logic [9:0] fruit_x,
    output logic [8:0] fruit_y,
    output logic [1:0] fruit_type,
    output logic       eat_evt,
    output logic [1:0] eat_type,
    output logic       spawn_fail
);

    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 9;
    localparam int unsigned TW  = 2;
    localparam int unsigned TCW = $clog2(RESPAWN_TICKS + 1);
    localparam int unsigned RCW = $clog2(MAX_RETRY + 1);

    localparam logic [XW-1:0] X_LIMIT = XW'(640);
    localparam logic [YW-1:0] Y_LIMIT = YW'(480);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_REQ,
        ST_CHECK,
        ST_ACTIVE
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [TW-1:0] t;
    } fruit_t;

    localparam fruit_t FRUIT_RST = '{x: XW'(320), y: YW'(240), t: TW'(1)};

    state_t         state_q,       state_d;
    logic [TCW-1:0] tick_cnt_q,    tick_cnt_d;
    logic [RCW-1:0] retry_q,       retry_d;
    fruit_t         cand_q,        cand_d;
    fruit_t         fruit_q,       fruit_d;
    logic           gen_req_q,     gen_req_d;
    logic           chk_req_q,     chk_req_d;
    logic           fruit_valid_q, fruit_valid_d;
    logic           eat_evt_q,     eat_evt_d;
    logic [TW-1:0]  eat_type_q,    eat_type_d;
    logic           spawn_fail_q,  spawn_fail_d;
    logic           reject_c;
    logic           cand_ok_c;

`ifdef FRUIT_TIMEOUT_EN
    localparam int unsigned LW = $clog2(LIFETIME_TICKS + 1);
    logic [LW-1:0]  life_q,        life_d;
`else
    // No lifetime counter in this build; the parameter only shapes the timeout build.
    if (LIFETIME_TICKS == 0) begin : g_no_lifetime
    end
`endif

    // Off-board or typeless candidates are rejected without bothering the snake body.
    assign cand_ok_c = (cand_x < X_LIMIT) && (cand_y < Y_LIMIT) && (cand_type != TW'(0));

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        retry_d       = retry_q;
        cand_d        = cand_q;
        fruit_d       = fruit_q;
        gen_req_d     = 1'b0;
        chk_req_d     = 1'b0;
        fruit_valid_d = fruit_valid_q;
        eat_evt_d     = 1'b0;
        eat_type_d    = eat_type_q;
        spawn_fail_d  = 1'b0;
        reject_c      = 1'b0;
`ifdef FRUIT_TIMEOUT_EN
        life_d        = life_q;
`endif

        unique case (state_q)
            ST_WAIT: begin
                if (tick) begin
                    if (tick_cnt_q == TCW'(RESPAWN_TICKS - 1)) begin
                        state_d    = ST_REQ;
                        tick_cnt_d = '0;
                        retry_d    = '0;
                        gen_req_d  = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TCW'(1);
                    end
                end
            end

            ST_REQ: begin
                // A response only counts while our request is actually on the wire.
                if (gen_req_q && cand_valid) begin
                    cand_d = '{x: cand_x, y: cand_y, t: cand_type};
                    if (cand_ok_c) begin
                        state_d   = ST_CHECK;
                        chk_req_d = 1'b1;
                    end else begin
                        reject_c = 1'b1;
                    end
                end else begin
                    gen_req_d = 1'b1;
                end
            end

            ST_CHECK: begin
                if (chk_req_q && chk_ack) begin
                    if (!chk_hit) begin
                        state_d       = ST_ACTIVE;
                        fruit_valid_d = 1'b1;
                        fruit_d       = cand_q;
`ifdef FRUIT_TIMEOUT_EN
                        life_d        = LW'(LIFETIME_TICKS);
`endif
                    end else begin
                        reject_c = 1'b1;
                    end
                end else begin
                    chk_req_d = 1'b1;
                end
            end

            ST_ACTIVE: begin
                // Eaten takes priority over a same-cycle expiry.
                if (eaten) begin
                    state_d       = ST_WAIT;
                    fruit_valid_d = 1'b0;
                    eat_evt_d     = 1'b1;
                    eat_type_d    = fruit_q.t;
                end
`ifdef FRUIT_TIMEOUT_EN
                else if (tick) begin
                    if (life_q <= LW'(1)) begin
                        state_d       = ST_WAIT;
                        fruit_valid_d = 1'b0;
                        life_d        = '0;
                    end else begin
                        life_d = life_q - LW'(1);
                    end
                end
`endif
            end

            default: state_d = ST_WAIT;
        endcase

        // Rejection: back to REQ (gen_req idles one cycle) or give up after the budget.
        if (reject_c) begin
            retry_d   = retry_q + RCW'(1);
            gen_req_d = 1'b0;
            if (retry_q == RCW'(MAX_RETRY - 1)) begin
                state_d      = ST_WAIT;
                spawn_fail_d = 1'b1;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            tick_cnt_q    <= '0;
            retry_q       <= '0;
            cand_q        <= '0;
            fruit_q       <= FRUIT_RST;
            gen_req_q     <= 1'b0;
            chk_req_q     <= 1'b0;
            fruit_valid_q <= 1'b0;
            eat_evt_q     <= 1'b0;
            eat_type_q    <= '0;
            spawn_fail_q  <= 1'b0;
`ifdef FRUIT_TIMEOUT_EN
            life_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            retry_q       <= retry_d;
            cand_q        <= cand_d;
            fruit_q       <= fruit_d;
            gen_req_q     <= gen_req_d;
            chk_req_q     <= chk_req_d;
            fruit_valid_q <= fruit_valid_d;
            eat_evt_q     <= eat_evt_d;
            eat_type_q    <= eat_type_d;
            spawn_fail_q  <= spawn_fail_d;
`ifdef FRUIT_TIMEOUT_EN
            life_q        <= life_d;
`endif
        end
    end

    assign gen_req     = gen_req_q;
    assign chk_req     = chk_req_q;
    assign chk_x       = cand_q.x;
    assign chk_y       = cand_q.y;
    assign fruit_valid = fruit_valid_q;
    assign fruit_x     = fruit_q.x;
    assign fruit_y     = fruit_q.y;
    assign fruit_type  = fruit_q.t;
    assign eat_evt     = eat_evt_q;
    assign eat_type    = eat_type_q;
    assign spawn_fail  = spawn_fail_q;

endmodule
